// File: rtl/seg7_pkg.sv
// Shared types and constants for the ADC voltage display: BCD widths,
// conversion FSM states and the active-low 7-segment code table.
package seg7_pkg;

  localparam int BIN_W       = 17;
  localparam int BCD_DIGITS  = 5;
  localparam int BCD_W       = 4 * BCD_DIGITS;
  localparam int DISP_DIGITS = 4;
  localparam int DISP_W      = 4 * DISP_DIGITS;

  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] DP_MASK   = 8'h7F;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_CONV,
    ST_LOAD
  } state_t;

  function automatic logic [7:0] seg_encode(input logic [3:0] digit);
    case (digit)
      4'd0:    seg_encode = SEG_0;
      4'd1:    seg_encode = SEG_1;
      4'd2:    seg_encode = SEG_2;
      4'd3:    seg_encode = SEG_3;
      4'd4:    seg_encode = SEG_4;
      4'd5:    seg_encode = SEG_5;
      4'd6:    seg_encode = SEG_6;
      4'd7:    seg_encode = SEG_7;
      4'd8:    seg_encode = SEG_8;
      4'd9:    seg_encode = SEG_9;
      default: seg_encode = SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/seg7_bin2bcd.sv
// Sequential double-dabble: one add-3/shift iteration per cycle, BIN_W
// iterations after a start pulse.
module seg7_bin2bcd
  import seg7_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [BIN_W-1:0] bin,
  output logic             done,
  output logic [BCD_W-1:0] bcd
);

  localparam int SR_W  = BCD_W + BIN_W;
  localparam int CNT_W = $clog2(BIN_W + 1);

  logic [SR_W-1:0]  shreg;
  logic [SR_W-1:0]  adjusted;
  logic [CNT_W-1:0] iter;

  always_comb begin
    // NOTE: full default before the conditional updates keeps this purely combinational (no latch).
    adjusted = shreg;
    for (int d = 0; d < BCD_DIGITS; d++) begin
      if (shreg[BIN_W + 4*d +: 4] >= 4'd5)
        adjusted[BIN_W + 4*d +: 4] = shreg[BIN_W + 4*d +: 4] + 4'd3;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg <= '0;
      iter  <= '0;
    end else if (start) begin
      shreg <= {{BCD_W{1'b0}}, bin};
      iter  <= CNT_W'(BIN_W);
    end else if (iter != '0) begin
      shreg <= {adjusted[SR_W-2:0], 1'b0};
      iter  <= iter - 1'b1;
    end
  end

  // done marks the cycle whose closing edge performs the final iteration,
  // so bcd is complete from the following cycle on.
  assign done = (iter == CNT_W'(1));
  assign bcd  = shreg[SR_W-1 -: BCD_W];

endmodule

// File: rtl/seg7_adc_display.sv
// ADC sample to X.XXX volts on a 4-digit multiplexed 7-segment display:
// scale, BCD-convert, latch atomically, then scan through the 74HC138.
module seg7_adc_display
  import seg7_pkg::*;
#(
  parameter int CLK_HZ    = 50_000_000,
  parameter int SCAN_HZ   = 1000,
  parameter int SCALE     = 129,
  parameter int BLANK_CYC = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] sample,
  input  logic       sample_valid,
  output logic [7:0] segdata,
  output logic [2:0] dig_sel,
  output logic       dig_en,
  output logic       busy
);

  localparam int SLOT_CYC = CLK_HZ / SCAN_HZ;
  localparam int TICK_W   = (SLOT_CYC > 1) ? $clog2(SLOT_CYC) : 1;

  state_t            state;
  logic [7:0]        sample_reg;
  logic [7:0]        pend_data;
  logic              pend_valid;
  logic [DISP_W-1:0] disp;
  logic              conv_start;
  logic              conv_done;
  logic [BCD_W-1:0]  conv_bcd;
  logic [BIN_W-1:0]  product;

  assign product    = {{(BIN_W-8){1'b0}}, sample_reg} * BIN_W'(SCALE);
  assign conv_start = (state == ST_MUL);

  seg7_bin2bcd u_bin2bcd (
    .clk   (clk),
    .rst   (rst),
    .start (conv_start),
    .bin   (product),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      busy       <= 1'b0;
      sample_reg <= '0;
      pend_valid <= 1'b0;
      pend_data  <= '0;
      disp       <= '0;
    end else begin
      if (sample_valid && (state == ST_MUL || state == ST_CONV)) begin
        pend_valid <= 1'b1;
        pend_data  <= sample;
      end
      case (state)
        ST_IDLE: if (sample_valid) begin
          sample_reg <= sample;
          state      <= ST_MUL;
          busy       <= 1'b1;
        end
        ST_MUL:  state <= ST_CONV;
        ST_CONV: if (conv_done) state <= ST_LOAD;
        ST_LOAD: begin
          // D0 is dropped: the display shows the product divided by ten.
          disp       <= conv_bcd[BCD_W-1:4];
          pend_valid <= 1'b0;
          if (sample_valid) begin
            sample_reg <= sample;
            state      <= ST_MUL;
          end else if (pend_valid) begin
            sample_reg <= pend_data;
            state      <= ST_MUL;
          end else begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  logic [TICK_W-1:0] tick, tick_nxt;
  logic [1:0]        idx, idx_nxt;
  logic [3:0]        digit;
  logic [7:0]        seg_nxt;

  // Segments are computed from the post-edge counters so segdata and
  // dig_sel always switch together.
  always_comb begin
    tick_nxt = tick + 1'b1;
    idx_nxt  = idx;
    if (tick == TICK_W'(SLOT_CYC - 1)) begin
      tick_nxt = '0;
      idx_nxt  = idx + 1'b1;
    end
    case (idx_nxt)
      2'd0:    digit = disp[3:0];
      2'd1:    digit = disp[7:4];
      2'd2:    digit = disp[11:8];
      default: digit = disp[15:12];
    endcase
    seg_nxt = seg_encode(digit);
    if (idx_nxt == 2'd3 && seg_nxt != SEG_BLANK)
      seg_nxt = seg_nxt & DP_MASK;
    if (int'(tick_nxt) < BLANK_CYC)
      seg_nxt = SEG_BLANK;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick    <= '0;
      idx     <= '0;
      segdata <= SEG_BLANK;
      dig_en  <= 1'b0;
    end else begin
      tick    <= tick_nxt;
      idx     <= idx_nxt;
      segdata <= seg_nxt;
      dig_en  <= 1'b1;
    end
  end

  assign dig_sel = {1'b0, idx};

endmodule

// File: tb/tb_seg7_adc_display.sv
// Scoreboard bench for seg7_adc_display: expected display words are queued
// at stimulus time and checked when each LOAD lands, plus full scan checks.
`timescale 1ns/1ps
module tb_seg7_adc_display;
  import seg7_pkg::*;

  localparam int CLK_HZ    = 32;
  localparam int SCAN_HZ   = 1;
  localparam int SCALE     = 129;
  localparam int BLANK_CYC = 4;
  localparam int SLOT_CYC  = CLK_HZ / SCAN_HZ;
  localparam logic [7:0] SEG_TBL [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                          8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] sample = '0;
  logic       sample_valid = 1'b0;
  logic [7:0] segdata;
  logic [2:0] dig_sel;
  logic       dig_en;
  logic       busy;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  logic [15:0] exp_q [$];
  bit load_pend = 1'b0;

  seg7_adc_display #(
    .CLK_HZ    (CLK_HZ),
    .SCAN_HZ   (SCAN_HZ),
    .SCALE     (SCALE),
    .BLANK_CYC (BLANK_CYC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .sample       (sample),
    .sample_valid (sample_valid),
    .segdata      (segdata),
    .dig_sel      (dig_sel),
    .dig_en       (dig_en),
    .busy         (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  // Display-register scoreboard: one expected word per LOAD.
  always @(negedge clk) begin
    logic [15:0] e;
    if (load_pend) begin
      load_pend = 1'b0;
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL load-scoreboard: unexpected load, display=%h", dut.disp);
      end else begin
        e = exp_q.pop_front();
        if (dut.disp !== e) begin
          miscompares++;
          $display("FAIL load-scoreboard: display=%h expected=%h", dut.disp, e);
        end
      end
    end
    if (!rst && dut.state == ST_LOAD) load_pend = 1'b1;
  end

  function automatic logic [15:0] expect_disp(input logic [7:0] s);
    int v;
    v = (int'(s) * SCALE) / 10;
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  function automatic logic [7:0] exp_code(input logic [3:0] d, input int slot);
    logic [7:0] code;
    code = (d <= 4'd9) ? SEG_TBL[d] : 8'hFF;
    if (slot == 3) code = code & 8'h7F;
    return code;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [7:0] s, output int t);
    sample       = s;
    sample_valid = 1'b1;
    step();
    sample_valid = 1'b0;
    t = cyc;
  endtask

  task automatic wait_idle(input string name, output int t_end);
    int g;
    g = 0;
    while (busy && g < 200) begin
      step();
      g++;
    end
    if (busy) begin
      vectors++;
      miscompares++;
      $display("FAIL %s: busy still high after %0d cycles", name, g);
    end
    t_end = cyc;
  endtask

  // Walks four full digit slots checking select order, blanking and codes.
  task automatic check_slots(input logic [15:0] e, input string name);
    logic [2:0] prev;
    logic [7:0] want, bad_val;
    int g, first, slot, blank_bad, dig_bad;
    prev = dig_sel;
    g = 0;
    while (dig_sel == prev && g < 2 * SLOT_CYC) begin
      step();
      g++;
    end
    vectors++;
    if (dig_sel == prev) begin
      miscompares++;
      $display("FAIL %s slot-align: dig_sel stuck at %0d", name, dig_sel);
      return;
    end
    first = int'(dig_sel);
    for (int s = 0; s < 4; s++) begin
      slot = (first + s) % 4;
      want = exp_code(e[4*slot +: 4], slot);
      blank_bad = -1;
      dig_bad   = -1;
      bad_val   = '0;
      vectors++;
      if (dig_sel !== 3'(slot)) begin
        miscompares++;
        $display("FAIL %s dig_sel: got %0d expected %0d", name, dig_sel, slot);
      end
      for (int c = 0; c < SLOT_CYC; c++) begin
        if (c < BLANK_CYC) begin
          if (segdata !== 8'hFF && blank_bad < 0) begin
            blank_bad = c;
            bad_val   = segdata;
          end
        end else if (segdata !== want && dig_bad < 0) begin
          dig_bad = c;
          bad_val = segdata;
        end
        step();
      end
      vectors += 2;
      if (blank_bad >= 0) begin
        miscompares++;
        $display("FAIL %s blank slot %0d: cycle %0d segdata=%h expected ff", name, slot, blank_bad, bad_val);
      end
      if (dig_bad >= 0) begin
        miscompares++;
        $display("FAIL %s digit slot %0d: cycle %0d segdata=%h expected %h", name, slot, dig_bad, bad_val, want);
      end
    end
  endtask

  task automatic check_reset_outputs(input string name);
    vectors += 4;
    if (segdata !== 8'hFF) begin miscompares++; $display("FAIL %s segdata: got %h expected ff", name, segdata); end
    if (dig_sel !== 3'd0)  begin miscompares++; $display("FAIL %s dig_sel: got %0d expected 0", name, dig_sel); end
    if (dig_en !== 1'b0)   begin miscompares++; $display("FAIL %s dig_en: got %b expected 0", name, dig_en); end
    if (busy !== 1'b0)     begin miscompares++; $display("FAIL %s busy: got %b expected 0", name, busy); end
  endtask

  task automatic check_span(input string name, input int got, input int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s busy-span: got %0d cycles expected %0d", name, got, want);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    check_reset_outputs("reset");
    rst = 1'b0;
    step();
    vectors++;
    if (dig_en !== 1'b1) begin
      miscompares++;
      $display("FAIL reset dig_en-after-release: got %b expected 1", dig_en);
    end
    check_slots(16'h0000, "reset-display");
  endtask

  task automatic test_single(input logic [7:0] s, input string name);
    int t0, t1;
    exp_q.push_back(expect_disp(s));
    strobe(s, t0);
    wait_idle(name, t1);
    check_span(name, t1 - t0, 19);
    check_slots(expect_disp(s), name);
  endtask

  task automatic test_back_to_back();
    int t0, tx, t1;
    exp_q.push_back(expect_disp(8'h10));
    exp_q.push_back(expect_disp(8'h30));
    strobe(8'h10, t0);
    step();
    strobe(8'h20, tx);
    step();
    strobe(8'h30, tx);
    wait_idle("back_to_back", t1);
    check_span("back_to_back", t1 - t0, 38);
    check_slots(16'h0619, "back_to_back");
  endtask

  task automatic test_load_strobe();
    int t0, tx, t1;
    exp_q.push_back(expect_disp(8'h40));
    exp_q.push_back(expect_disp(8'h99));
    strobe(8'h40, t0);
    while (cyc < t0 + 2) step();
    strobe(8'h55, tx);
    while (cyc < t0 + 18) step();
    strobe(8'h99, tx);
    wait_idle("load_strobe", t1);
    check_span("load_strobe", t1 - t0, 38);
    check_slots(16'h1973, "load_strobe");
  endtask

  task automatic test_reset_abort();
    int t0, t1;
    exp_q.push_back(expect_disp(8'hFF));
    strobe(8'hFF, t0);
    wait_idle("abort-setup", t1);
    check_slots(16'h3289, "abort-setup");
    strobe(8'h80, t0);
    repeat (8) step();
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL abort precondition busy: got %b expected 1", busy);
    end
    #2 rst = 1'b1;
    #1 check_reset_outputs("abort-async");
    repeat (2) step();
    rst = 1'b0;
    check_slots(16'h0000, "abort-display");
  endtask

  initial begin
    test_reset();
    test_single(8'hFF, "full_scale");
    test_single(8'h80, "mid_scale");
    test_single(8'h00, "zero");
    test_back_to_back();
    test_load_strobe();
    test_reset_abort();
    repeat (2) step();
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard-drain: %0d loads missing, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
